// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes the RISC-V instruction format and sign-extended immediate,
// then holds them in a single valid/ready output register with a saturating count of legal accepts.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] acc_cnt
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic [2:0]       w_fmt;
   logic [XLEN-1:0]  w_imm;
   logic             w_illegal;
   logic             w_accept;

   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_imm;
   logic [2:0]       r_out_fmt;
   logic             r_out_illegal;
   logic [CNT_W-1:0] r_acc_cnt;

   assign w_opcode = inst[6:0];
   assign w_funct3 = inst[14:12];

   always_comb begin
      w_fmt     = FMT_ILL;
      w_imm     = '0;
      w_illegal = 1'b0;
      case (w_opcode)
         7'b0000011, 7'b1100111, 7'b1110011: begin
            w_fmt = FMT_I;
            w_imm = XLEN'($signed(inst[31:20]));
         end
         7'b0010011: begin
            w_fmt = FMT_I;
            // Shift-immediates carry an unsigned shamt; funct7 bits must not sign-extend.
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
               w_imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            else
               w_imm = XLEN'($signed(inst[31:20]));
         end
         7'b0100011: begin
            w_fmt = FMT_S;
            w_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         end
         7'b1100011: begin
            w_fmt = FMT_B;
            w_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            w_fmt = FMT_U;
            w_imm = XLEN'($signed({inst[31:12], 12'b0}));
         end
         7'b1101111: begin
            w_fmt = FMT_J;
            w_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         end
         7'b0110011: begin
            w_fmt = FMT_R;
         end
         default: begin
            w_fmt     = FMT_ILL;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Handshake: a transfer happens on a rising edge where valid && ready on that side.
   // in_ready is combinational: the lone output register may load when empty or draining.
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_imm     <= '0;
         r_out_fmt     <= FMT_R;
         r_out_illegal <= 1'b0;
         r_acc_cnt     <= '0;
      end else if (w_accept) begin
         r_out_valid   <= 1'b1;
         r_out_imm     <= w_imm;
         r_out_fmt     <= w_fmt;
         r_out_illegal <= w_illegal;
         if (!w_illegal && r_acc_cnt != {CNT_W{1'b1}})
            r_acc_cnt <= r_acc_cnt + 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_imm     = r_out_imm;
   assign out_fmt     = r_out_fmt;
   assign out_illegal = r_out_illegal;
   assign acc_cnt     = r_acc_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: main XLEN=32 instance plus CNT_W=4 and XLEN=64 instances
// sharing one input stream.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] inst;
   logic        out_ready;

   logic        in_ready,   in_ready_s,   in_ready_w;
   logic        out_valid,  out_valid_s,  out_valid_w;
   logic [31:0] out_imm,    out_imm_s;
   logic [63:0] out_imm_w;
   logic [2:0]  out_fmt,    out_fmt_s,    out_fmt_w;
   logic        out_ill,    out_ill_s,    out_ill_w;
   logic [15:0] acc_cnt,    acc_cnt_w;
   logic [3:0]  acc_cnt_s;

   int n_cmp;
   int n_err;

   // bench model of the handshake and counter
   logic m_valid;
   int   m_cnt;

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_ill), .acc_cnt(acc_cnt)
   );

   imm_gen_pipe #(.XLEN(32), .CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .inst(inst),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_imm(out_imm_s), .out_fmt(out_fmt_s),
      .out_illegal(out_ill_s), .acc_cnt(acc_cnt_s)
   );

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .inst(inst),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_imm(out_imm_w), .out_fmt(out_fmt_w),
      .out_illegal(out_ill_w), .acc_cnt(acc_cnt_w)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check ready, sample 1ns after the rising edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic legal);
      logic exp_ready;
      logic acc;
      @(negedge clk);
      in_valid  = v;
      inst      = ins;
      out_ready = rdy;
      #1;
      exp_ready = !m_valid || rdy;
      check("in_ready", in_ready, exp_ready);
      acc = v && exp_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         m_valid = 1'b1;
         if (legal) m_cnt++;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      check("out_valid", out_valid, m_valid);
      check("acc_cnt", acc_cnt, 64'(m_cnt));
      check("acc_cnt_sat", acc_cnt_s, 64'((m_cnt > 15) ? 15 : m_cnt));
   endtask

   task automatic check_out(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                            input logic ill);
      check({tag, "_imm"}, out_imm, imm);
      check({tag, "_fmt"}, out_fmt, fmt);
      check({tag, "_ill"}, out_ill, ill);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      m_valid   = 1'b0;
      m_cnt     = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      inst      = 32'hFFC12083;
      out_ready = 1'b1;

      // reset state, with a transfer presented during reset that must be discarded
      @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_imm", out_imm, 0);
      check("rst_fmt", out_fmt, 0);
      check("rst_cnt", acc_cnt, 0);
      check("rst_ready", in_ready, 1);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;

      // formats, out_ready held 1, back-to-back
      step(1, 32'hFFC12083, 1, 1); check_out("lw",  32'hFFFFFFFC, 3'd1, 0);
      check("x64_imm", out_imm_w, 64'hFFFFFFFFFFFFFFFC);
      step(1, 32'h00512423, 1, 1); check_out("sw",  32'h00000008, 3'd2, 0);
      step(1, 32'hFE000CE3, 1, 1); check_out("beq", 32'hFFFFFFF8, 3'd3, 0);
      step(1, 32'h123450B7, 1, 1); check_out("lui", 32'h12345000, 3'd4, 0);
      step(1, 32'h0010006F, 1, 1); check_out("jal", 32'h00000800, 3'd5, 0);
      step(1, 32'h41F0D093, 1, 1); check_out("srai", 32'h0000001F, 3'd1, 0);
      check("x64_srai", out_imm_w, 64'h000000000000001F);
      step(1, 32'h002081B3, 1, 1); check_out("add", 32'h00000000, 3'd0, 0);
      step(1, 32'h0000007F, 1, 0); check_out("ill", 32'h00000000, 3'd7, 1);
      check("x64_ill", out_imm_w, 64'h0);

      // idle: in_valid low drains, then inst ignored
      step(0, 32'hFFC12083, 1, 1);
      step(0, 32'h00512423, 0, 1); check_out("idle", 32'h00000000, 3'd7, 1);

      // backpressure
      step(1, 32'h123450B7, 1, 1); check_out("bp_lui", 32'h12345000, 3'd4, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h00512423, 0, 1); check_out("bp_hold", 32'h12345000, 3'd4, 0);
      end
      step(1, 32'h00512423, 1, 1); check_out("bp_rel", 32'h00000008, 3'd2, 0);
      step(1, 32'hFE000CE3, 1, 1); check_out("bp_b2b", 32'hFFFFFFF8, 3'd3, 0);
      step(0, 32'h0, 1, 1);

      // saturation of the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         step(1, 32'h0010006F, 1, 1);
      end
      check("sat_final", acc_cnt_s, 15);
      step(1, 32'h0000007F, 1, 0); check_out("ill2", 32'h00000000, 3'd7, 1);

      // asynchronous reset while stalled with a valid result
      step(1, 32'h123450B7, 0, 1);
      step(1, 32'h123450B7, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_imm", out_imm, 0);
      check("arst_cnt", acc_cnt, 0);
      check("arst_cnt_sat", acc_cnt_s, 0);
      check("arst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      check("arst_nocap", out_valid, 0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      m_valid  = 1'b0;
      m_cnt    = 0;
      step(1, 32'hFFC12083, 1, 1); check_out("post_rst", 32'hFFFFFFFC, 3'd1, 0);
      step(0, 32'h0, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port inst  input  32  instruction word to decode.
REQ-008 SHALL have port out_valid  output  1  registered result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-011 SHALL have port out_fmt  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-012 SHALL have port out_illegal  output  1  opcode not recognised.
REQ-013 SHALL have port acc_cnt  output  CNT_W  count of legal instructions accepted.

Function
REQ-014 SHALL decode format from inst[6:0]: 0000011/0010011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; all others -> illegal.
REQ-015 SHALL form I imm = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; each sign-extended from its MSB to XLEN.
REQ-016 SHALL form U imm = {inst[31:12],12'b0}, sign-extended from bit 31 to XLEN.
REQ-017 SHALL, for opcode 0010011 with inst[14:12] = 001 or 101, output zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64; out_fmt = I.
REQ-018 SHALL output out_imm = 0 for R and illegal formats; out_illegal = 1 only for illegal.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational, single output register, no skid).
REQ-020 SHALL capture decode results into the output register on a cycle where in_valid && in_ready; latency exactly 1 cycle to out_valid.
REQ-021 SHALL clear out_valid on a cycle where out_valid && out_ready && !(in_valid && in_ready).
REQ-022 SHALL hold out_imm, out_fmt, out_illegal stable while out_valid && !out_ready.
REQ-023 SHALL sustain one instruction per cycle when out_ready is held 1 (simultaneous drain and load in the same cycle).
REQ-024 SHALL increment acc_cnt by 1 on each accepted non-illegal instruction; illegal accepts do not count.
REQ-025 SHALL saturate acc_cnt at 2^CNT_W-1; no wrap-around.
REQ-026 SHALL ignore inst while in_valid = 0; output register unchanged.

Reset
REQ-027 SHALL, on rst = 1, asynchronously set out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0, acc_cnt = 0.
REQ-028 SHALL, during rst, drive in_ready = 1 (follows REQ-019 with out_valid = 0) and discard any in-flight result; a transfer presented in the reset cycle is not captured.
REQ-029 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL cover formats (XLEN=32, out_ready=1): 0xFFC12083 -> imm 0xFFFFFFFC fmt 1; 0x00512423 -> 0x00000008 fmt 2; 0xFE000CE3 -> 0xFFFFFFF8 fmt 3; 0x123450B7 -> 0x12345000 fmt 4; 0x0010006F -> 0x00000800 fmt 5; each out_valid exactly 1 cycle after accept.
REQ-031 SHALL cover shamt: 0x41F0D093 (srai x1,x1,31) -> imm 0x0000001F fmt 1, not sign-extended from bit 31.
REQ-032 SHALL cover backpressure: accept 0x123450B7, hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs unchanged; release -> next inst accepted same cycle, back-to-back throughput 1/cycle.
REQ-033 SHALL cover illegal: inst 0x0000007F -> out_illegal 1, fmt 7, imm 0, acc_cnt unchanged.
REQ-034 SHALL cover saturation and XLEN: CNT_W = 4, 20 legal accepts -> acc_cnt = 15; XLEN = 64, inst 0xFFC12083 -> imm 0xFFFFFFFFFFFFFFFC.
REQ-035 SHALL cover reset mid-operation: rst asserted asynchronously while out_valid = 1 and out_ready = 0 -> out_valid, out_imm, acc_cnt = 0 before the next clock edge; first accept after release decodes normally.
